fpadd_rne_pipe: RTL and testbench
=================================

# fpadd_rne_pipe

Parametrised, three-stage pipelined floating-point adder/subtractor with valid/ready flow control, IEEE round-to-nearest-even, special-value handling and exception flags. It supersedes the fixed-format two-stage FP16 adder in the MAC datapath. One instance serves both FP16 (EXP_W=5, MAN_W=10) and BF16 (EXP_W=8, MAN_W=7) accumulators, and can be stalled by the downstream writeback.

## Interface
- EXP_W, 5, exponent width; legal range 4..8
- MAN_W, 10, stored mantissa width, hidden bit excluded; legal range 3..23
- TAG_W, 4, width of the sideband tag carried alongside each operation
- clk  in  1  clock; all flops on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  block accepts an operand pair this cycle
- opr_a, opr_b  in  1+EXP_W+MAN_W  operands, {sign, exp, mantissa}
- op_sub  in  1  1 computes a-b, which is a+(-b)
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts the result
- result  out  1+EXP_W+MAN_W  rounded sum
- out_tag  out  TAG_W  tag of the operation that produced result
- flags  out  4  {invalid, overflow, underflow, inexact}

## Operation
- Formats: BIAS = 2^(EXP_W-1)-1.
  - An exponent of all-ones with mantissa 0 is infinity; with a nonzero mantissa it is NaN.
  - An exponent of 0 is zero. Subnormal inputs are flushed to a signed zero, and no flag is raised for this.
- Stage 1, unpack/align:
  - Compute the effective sign of b (sb ^ op_sub).
  - Swap the operands so that the larger magnitude is first. Compare {exp, mantissa}.
  - Prepend the hidden bit and append 3 bits (guard, round, sticky).
  - Right-shift the smaller operand by the exponent difference. The shift saturates at MAN_W+4. Every bit shifted out ORs into sticky.
  - Classify specials.
- Stage 2, add:
  - Use a MAN_W+5-bit adder with one carry bit.
  - Add when the effective signs are equal, otherwise subtract. The result is never negative because of the swap.
  - Sign = sign of the larger operand.
- Stage 3, normalise/round:
  - On carry-out, right-shift by 1 (keeping sticky) and exponent+1. Otherwise, left-shift by leading-zero count and subtract it from the exponent.
  - RNE: round up when guard & (round | sticky | lsb). A mantissa overflow after rounding increments the exponent.
- Special results, in priority order:
  1. Any NaN input, or inf + (-inf) effective: canonical qNaN {0, all-ones, 1 followed by zeros}. Raises invalid.
  2. Any inf operand: that inf.
  3. Exact zero sum: +0, unless both operands are -0 effective, which gives -0.
  4. Exponent ≥ all-ones after rounding: signed inf. Raises overflow and inexact.
  5. Exponent ≤ 0 after normalisation: signed zero. Raises underflow and inexact.
- inexact is set whenever any of guard, round or sticky is nonzero before rounding.
- in_tag travels with the data unchanged.

## Timing
- Pipeline and handshake:
  - Latency is 3 cycles from the in_valid&in_ready edge to out_valid, with no stalls.
  - Throughput is 1 per cycle.
  - Global advance: adv = !out_valid | out_ready.
  - in_ready = adv. It depends combinationally on out_ready.
  - All stage registers, including per-stage valid bits, load only when adv. Bubbles propagate as valid=0.
- Output hold: while out_valid & !out_ready, result, out_tag and flags are held stable.
- Reset:
  - Asserting reset_n low clears all valid bits immediately, at any point, including mid-operation. In-flight operations are discarded.
  - Reset values: out_valid=0, result=0, out_tag=0, flags=0. in_ready=1 after reset.
- Simultaneous accept and emit in one cycle is legal and loses nothing.

## Structure
- Package fpadd_pkg holds:
  - format constants: BIAS, the all-ones exponent, the qNaN pattern
  - the flag bit indices: invalid=3, overflow=2, underflow=1, inexact=0
  - the FP16 and BF16 presets
- One sub-module, fp_lzc: a parametrised leading-zero counter used by stage 3.

## Test plan
- FP16, no backpressure, in this sequence:
  - 0x3C00 + 0x3C00 -> 0x4000, flags 0, out_valid exactly 3 cycles after accept.
  - 0x3C00 + 0x1000 (tie) -> 0x3C00, inexact.
  - 0x3C01 + 0x1000 -> 0x3C02, inexact.
- FP16 specials:
  - 0x7BFF + 0x7BFF -> 0x7C00, overflow|inexact.
  - 0x7C00 + 0xFC00 -> 0x7E00, invalid.
  - 0x7E01 + 0x3C00 -> 0x7E00, invalid.
  - 0x3C00 with op_sub, minus 0x3C00 -> 0x0000.
  - 0x8000 + 0x8000 -> 0x8000.
- FP16 subtraction with sticky and underflow:
  - 0x3C00 - 0x0001 (subnormal flushed) -> 0x3C00, no flags.
  - 0x0400 - 0x03FF: the flushed subnormal leaves 0x0400 unchanged, flags 0.
  - 0x0401 - 0x0400 -> 0x0000, underflow|inexact.
- BF16 instance:
  - 0x3F80 + 0x3F80 -> 0x4000.
  - 0x3F80 + 0xBF80 -> 0x0000.
  - 0x7F7F + 0x7F7F -> 0x7F80, overflow.
- Backpressure:
  - Issue tags 1..6 back-to-back with out_ready=0. in_ready drops after 3 accepts, and result stays stable.
  - Release out_ready. Tags emerge in order 1..6 and none is lost or duplicated.
- Asynchronous reset:
  - Pull reset_n low mid-stream, between clock edges. out_valid drops at once, with no clock edge needed.
  - After release, the first new operation returns after 3 cycles with the correct result.

Source files
------------

// File: rtl/fpadd_rne_pipe_pkg.sv
// ============================================================================
// Package : fpadd_pkg
// Brief   : Format helpers, flag indices and format presets for fpadd_rne_pipe.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package fpadd_pkg;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;

  function automatic int fpBias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

  function automatic int fpExpOnes(input int expW);
    return (1 << expW) - 1;
  endfunction

  // Canonical quiet NaN: positive sign, all-ones exponent, mantissa MSB only
  function automatic logic [31:0] fpQnan(input int expW, input int manW);
    logic [31:0] v;
    v = 32'(fpExpOnes(expW)) << manW;
    v = v | (32'd1 << (manW - 1));
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpadd_rne_pipe_if.sv
// ============================================================================
// Interface : fpadd_rne_pipe_if
// Brief     : Operand/result handshake bundle for fpadd_rne_pipe.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface fpadd_rne_pipe_if
  import fpadd_pkg::*;
#(
  parameter int EXP_W = FP16_EXP_W,
  parameter int MAN_W = FP16_MAN_W,
  parameter int TAG_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   opr_a;
  logic [EXP_W+MAN_W:0]   opr_b;
  logic                   op_sub;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   result;
  logic [TAG_W-1:0]       out_tag;
  logic [3:0]             flags;

  modport master (
    output in_valid, opr_a, opr_b, op_sub, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, flags
  );

  modport slave (
    input  in_valid, opr_a, opr_b, op_sub, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, flags
  );
endinterface

`default_nettype wire

// File: rtl/fpadd_rne_pipe_lzc.sv
// ============================================================================
// Module : fp_lzc
// Brief  : Parametrised leading-zero counter; an all-zero input returns WIDTH.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_lzc #(
  parameter int WIDTH = 14,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  wire  [WIDTH-1:0] i_value,
  output logic [CNT_W-1:0] o_count
);

  // Scanning upward lets the highest set bit win
  always_comb begin
    o_count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_value[i]) o_count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpadd_rne_pipe.sv
// ============================================================================
// Module : fpadd_rne_pipe
// Brief  : Three-stage pipelined FP add/sub, round-to-nearest-even, valid/ready.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fpadd_rne_pipe
  import fpadd_pkg::*;
#(
  parameter int EXP_W = FP16_EXP_W,
  parameter int MAN_W = FP16_MAN_W,
  parameter int TAG_W = 4
) (
  input wire             clk,
  input wire             reset_n,
  fpadd_rne_pipe_if.slave bus
);

  localparam int c_width = 1 + EXP_W + MAN_W;
  localparam int c_sigW  = MAN_W + 4;
  localparam int c_sumW  = MAN_W + 5;
  localparam int c_lzW   = $clog2(c_sigW + 1);
  localparam int c_eW    = EXP_W + 2;
  localparam logic [EXP_W-1:0]   c_expOnes     = '1;
  localparam logic [c_eW-1:0]    c_expOnesWide = c_eW'(fpExpOnes(EXP_W));
  localparam logic [c_width-1:0] c_qNan        = c_width'(fpQnan(EXP_W, MAN_W));

  logic w_adv;
  logic r_outValid;
  assign w_adv        = !r_outValid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // ---------------- stage 1: unpack, swap, align ----------------
  logic                     w_signA, w_signB, w_zeroA, w_zeroB;
  logic                     w_nanA, w_nanB, w_infA, w_infB, w_swap;
  logic [EXP_W-1:0]         w_expA, w_expB, w_expL, w_expS, w_diff;
  logic [MAN_W-1:0]         w_manA, w_manB;
  logic [c_width-2:0]       w_magA, w_magB, w_magL, w_magS;
  logic [c_sigW-1:0]        w_sigL, w_sigS, w_shifted, w_alignS;
  logic                     w_lost;

  assign w_signA = bus.opr_a[c_width-1];
  assign w_signB = bus.opr_b[c_width-1] ^ bus.op_sub;
  assign w_expA  = bus.opr_a[c_width-2 -: EXP_W];
  assign w_expB  = bus.opr_b[c_width-2 -: EXP_W];
  assign w_manA  = bus.opr_a[MAN_W-1:0];
  assign w_manB  = bus.opr_b[MAN_W-1:0];
  assign w_zeroA = (w_expA == '0);
  assign w_zeroB = (w_expB == '0);
  assign w_nanA  = (w_expA == c_expOnes) && (w_manA != '0);
  assign w_nanB  = (w_expB == c_expOnes) && (w_manB != '0);
  assign w_infA  = (w_expA == c_expOnes) && (w_manA == '0);
  assign w_infB  = (w_expB == c_expOnes) && (w_manB == '0);

  // Subnormals are flushed here so they compare and align as true zeros
  assign w_magA  = w_zeroA ? '0 : {w_expA, w_manA};
  assign w_magB  = w_zeroB ? '0 : {w_expB, w_manB};
  assign w_swap  = (w_magB > w_magA);
  assign w_magL  = w_swap ? w_magB : w_magA;
  assign w_magS  = w_swap ? w_magA : w_magB;
  assign w_expL  = w_magL[c_width-2 -: EXP_W];
  assign w_expS  = w_magS[c_width-2 -: EXP_W];
  assign w_sigL  = {(w_expL != '0), w_magL[MAN_W-1:0], 3'b000};
  assign w_sigS  = {(w_expS != '0), w_magS[MAN_W-1:0], 3'b000};
  assign w_diff  = w_expL - w_expS;

  always_comb begin
    w_shifted = w_sigS;
    w_lost    = 1'b0;
    if (int'(w_diff) >= c_sigW) begin
      w_shifted = '0;
      w_lost    = |w_sigS;
    end else begin
      w_shifted = w_sigS >> w_diff;
      w_lost    = |(w_sigS & ~({c_sigW{1'b1}} << w_diff));
    end
  end
  assign w_alignS = {w_shifted[c_sigW-1:1], w_shifted[0] | w_lost};

  logic                 r_s1Valid, r_s1Sign, r_s1Sub, r_s1Nan, r_s1Inf, r_s1InfSign, r_s1NegZero;
  logic [TAG_W-1:0]     r_s1Tag;
  logic [EXP_W-1:0]     r_s1Exp;
  logic [c_sigW-1:0]    r_s1SigL, r_s1SigS;

  // ---------------- stage 2: magnitude add/subtract ----------------
  logic [c_sumW-1:0]    w_sum;
  assign w_sum = r_s1Sub ? ({1'b0, r_s1SigL} - {1'b0, r_s1SigS})
                         : ({1'b0, r_s1SigL} + {1'b0, r_s1SigS});

  logic                 r_s2Valid, r_s2Sign, r_s2Nan, r_s2Inf, r_s2InfSign, r_s2NegZero;
  logic [TAG_W-1:0]     r_s2Tag;
  logic [EXP_W-1:0]     r_s2Exp;
  logic [c_sumW-1:0]    r_s2Sum;

  // ---------------- stage 3: normalise, round, specials ----------------
  logic [c_lzW-1:0]     w_lzCount;
  logic [c_sigW-1:0]    w_norm;
  logic [c_eW-1:0]      w_expNorm, w_expRnd;
  logic [MAN_W+1:0]     w_mantRnd;
  logic [MAN_W-1:0]     w_frac;
  logic                 w_roundUp, w_inexact, w_uflow, w_oflow;
  logic [c_width-1:0]   w_result;
  logic [3:0]           w_flags;

  fp_lzc #(.WIDTH(c_sigW)) u_lzc (
    .i_value (r_s2Sum[c_sigW-1:0]),
    .o_count (w_lzCount)
  );

  always_comb begin
    if (r_s2Sum[c_sumW-1]) begin
      w_norm    = {r_s2Sum[c_sumW-1:2], |r_s2Sum[1:0]};
      w_expNorm = {2'b00, r_s2Exp} + c_eW'(1);
    end else begin
      w_norm    = r_s2Sum[c_sigW-1:0] << w_lzCount;
      w_expNorm = {2'b00, r_s2Exp} - c_eW'(w_lzCount);
    end
  end

  assign w_inexact = |w_norm[2:0];
  assign w_roundUp = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_mantRnd = {1'b0, w_norm[c_sigW-1:3]} + (MAN_W + 2)'(w_roundUp);
  assign w_expRnd  = w_expNorm + c_eW'(w_mantRnd[MAN_W+1]);
  assign w_frac    = w_mantRnd[MAN_W+1] ? w_mantRnd[MAN_W:1] : w_mantRnd[MAN_W-1:0];
  assign w_uflow   = w_expNorm[c_eW-1] || (w_expNorm == '0);
  assign w_oflow   = !w_expRnd[c_eW-1] && (w_expRnd >= c_expOnesWide);

  always_comb begin
    w_result = {r_s2Sign, w_expRnd[EXP_W-1:0], w_frac};
    w_flags  = '0;
    w_flags[FLAG_INEXACT] = w_inexact;
    if (r_s2Nan) begin
      w_result = c_qNan;
      w_flags  = '0;
      w_flags[FLAG_INVALID] = 1'b1;
    end else if (r_s2Inf) begin
      w_result = {r_s2InfSign, c_expOnes, {MAN_W{1'b0}}};
      w_flags  = '0;
    end else if (r_s2Sum == '0) begin
      w_result = {r_s2NegZero, {(c_width-1){1'b0}}};
      w_flags  = '0;
    end else if (w_oflow) begin
      w_result = {r_s2Sign, c_expOnes, {MAN_W{1'b0}}};
      w_flags  = '0;
      w_flags[FLAG_OVERFLOW] = 1'b1;
      w_flags[FLAG_INEXACT]  = 1'b1;
    end else if (w_uflow) begin
      w_result = {r_s2Sign, {(c_width-1){1'b0}}};
      w_flags  = '0;
      w_flags[FLAG_UNDERFLOW] = 1'b1;
      w_flags[FLAG_INEXACT]   = 1'b1;
    end
  end

  logic [c_width-1:0]   r_result;
  logic [TAG_W-1:0]     r_outTag;
  logic [3:0]           r_flags;

  // Every stage advances together; a stalled output freezes the whole pipe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1Valid   <= 1'b0;  r_s1Tag     <= '0;    r_s1Sign    <= 1'b0;
      r_s1Sub     <= 1'b0;  r_s1Exp     <= '0;    r_s1SigL    <= '0;
      r_s1SigS    <= '0;    r_s1Nan     <= 1'b0;  r_s1Inf     <= 1'b0;
      r_s1InfSign <= 1'b0;  r_s1NegZero <= 1'b0;
      r_s2Valid   <= 1'b0;  r_s2Tag     <= '0;    r_s2Sign    <= 1'b0;
      r_s2Exp     <= '0;    r_s2Sum     <= '0;    r_s2Nan     <= 1'b0;
      r_s2Inf     <= 1'b0;  r_s2InfSign <= 1'b0;  r_s2NegZero <= 1'b0;
      r_outValid  <= 1'b0;  r_result    <= '0;    r_outTag    <= '0;
      r_flags     <= '0;
    end else if (w_adv) begin
      r_s1Valid   <= bus.in_valid;
      r_s1Tag     <= bus.in_tag;
      r_s1Sign    <= w_swap ? w_signB : w_signA;
      r_s1Sub     <= (w_signA != w_signB);
      r_s1Exp     <= w_expL;
      r_s1SigL    <= w_sigL;
      r_s1SigS    <= w_alignS;
      r_s1Nan     <= w_nanA || w_nanB || (w_infA && w_infB && (w_signA != w_signB));
      r_s1Inf     <= w_infA || w_infB;
      r_s1InfSign <= w_infA ? w_signA : w_signB;
      r_s1NegZero <= w_zeroA && w_zeroB && w_signA && w_signB;

      r_s2Valid   <= r_s1Valid;
      r_s2Tag     <= r_s1Tag;
      r_s2Sign    <= r_s1Sign;
      r_s2Exp     <= r_s1Exp;
      r_s2Sum     <= w_sum;
      r_s2Nan     <= r_s1Nan;
      r_s2Inf     <= r_s1Inf;
      r_s2InfSign <= r_s1InfSign;
      r_s2NegZero <= r_s1NegZero;

      r_outValid  <= r_s2Valid;
      r_result    <= w_result;
      r_outTag    <= r_s2Tag;
      r_flags     <= w_flags;
    end
  end

  assign bus.out_valid = r_outValid;
  assign bus.result    = r_result;
  assign bus.out_tag   = r_outTag;
  assign bus.flags     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_fpadd_rne_pipe.sv
// ============================================================================
// Module : tb_fpadd_rne_pipe
// Brief  : Scoreboard bench for FP16 and BF16 instances of fpadd_rne_pipe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fpadd_rne_pipe;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    logic [3:0]  tag;
  } exp_t;

  localparam logic [3:0] c_fNone = 4'b0000;
  localparam logic [3:0] c_fInx  = 4'b0001;
  localparam logic [3:0] c_fUnf  = 4'b0011;
  localparam logic [3:0] c_fOvf  = 4'b0101;
  localparam logic [3:0] c_fInv  = 4'b1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int out16  = 0;
  int outBf  = 0;
  exp_t q16[$];
  exp_t qBf[$];
  exp_t e16, eBf;
  logic [3:0] tag16 = 4'd0;
  logic [3:0] tagBf = 4'd0;

  fpadd_rne_pipe_if #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) bus16 ();
  fpadd_rne_pipe_if #(.EXP_W(8), .MAN_W(7),  .TAG_W(4)) busBf ();

  fpadd_rne_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .bus(bus16)
  );
  fpadd_rne_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) u_dutBf (
    .clk(clk), .reset_n(reset_n), .bus(busBf)
  );

  // Output scoreboards: a transfer happens at the posedge following this sample
  always @(negedge clk) begin
    if (reset_n && bus16.out_valid && bus16.out_ready) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL fp16_unexpected: got result=%h tag=%h, required no output",
                 bus16.result, bus16.out_tag);
      end else begin
        e16 = q16.pop_front();
        out16++;
        if (bus16.result !== e16.res || bus16.flags !== e16.flg || bus16.out_tag !== e16.tag) begin
          errors++;
          $display("FAIL fp16_result: got result=%h flags=%b tag=%h, required result=%h flags=%b tag=%h",
                   bus16.result, bus16.flags, bus16.out_tag, e16.res, e16.flg, e16.tag);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && busBf.out_valid && busBf.out_ready) begin
      checks++;
      if (qBf.size() == 0) begin
        errors++;
        $display("FAIL bf16_unexpected: got result=%h tag=%h, required no output",
                 busBf.result, busBf.out_tag);
      end else begin
        eBf = qBf.pop_front();
        outBf++;
        if (busBf.result !== eBf.res || busBf.flags !== eBf.flg || busBf.out_tag !== eBf.tag) begin
          errors++;
          $display("FAIL bf16_result: got result=%h flags=%b tag=%h, required result=%h flags=%b tag=%h",
                   busBf.result, busBf.flags, busBf.out_tag, eBf.res, eBf.flg, eBf.tag);
        end
      end
    end
  end

  // Presents an operation and holds it until accepted; in_valid stays high on return
  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [15:0] res, input logic [3:0] flg);
    int n = 0;
    bus16.in_valid = 1'b1;
    bus16.opr_a    = a;
    bus16.opr_b    = b;
    bus16.op_sub   = sub;
    bus16.in_tag   = tag16;
    @(negedge clk);
    while (!bus16.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus16.in_ready) begin
      checks++;
      errors++;
      $display("FAIL fp16_accept_timeout: got in_ready=0, required 1 within 50 cycles");
    end else begin
      q16.push_back('{res: res, flg: flg, tag: tag16});
    end
    @(posedge clk);
    #1;
    tag16 = tag16 + 4'd1;
  endtask

  task automatic issueBf(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [15:0] res, input logic [3:0] flg);
    int n = 0;
    busBf.in_valid = 1'b1;
    busBf.opr_a    = a;
    busBf.opr_b    = b;
    busBf.op_sub   = sub;
    busBf.in_tag   = tagBf;
    @(negedge clk);
    while (!busBf.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!busBf.in_ready) begin
      checks++;
      errors++;
      $display("FAIL bf16_accept_timeout: got in_ready=0, required 1 within 50 cycles");
    end else begin
      qBf.push_back('{res: res, flg: flg, tag: tagBf});
    end
    @(posedge clk);
    #1;
    tagBf = tagBf + 4'd1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    bus16.in_valid = 1'b0;
    busBf.in_valid = 1'b0;
    while ((q16.size() != 0 || qBf.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q16.size() != 0 || qBf.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d/%0d pending, required 0", name, q16.size(), qBf.size());
    end
  endtask

  // Counts posedges from the accept edge (inclusive) until out_valid is seen
  task automatic checkLatency16(input string name);
    int n = 1;
    bus16.in_valid = 1'b0;
    while (!bus16.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required 3", name, n);
    end
  endtask

  task automatic test_reset();
    bus16.in_valid = 1'b0; bus16.opr_a = '0; bus16.opr_b = '0; bus16.op_sub = 1'b0;
    bus16.in_tag = '0; bus16.out_ready = 1'b1;
    busBf.in_valid = 1'b0; busBf.opr_a = '0; busBf.opr_b = '0; busBf.op_sub = 1'b0;
    busBf.in_tag = '0; busBf.out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.result !== 16'h0 || bus16.out_tag !== 4'h0 ||
        bus16.flags !== 4'h0 || bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_fp16: got valid=%b result=%h tag=%h flags=%b ready=%b, required 0 0000 0 0000 1",
               bus16.out_valid, bus16.result, bus16.out_tag, bus16.flags, bus16.in_ready);
    end
    checks++;
    if (busBf.out_valid !== 1'b0 || busBf.result !== 16'h0 || busBf.out_tag !== 4'h0 ||
        busBf.flags !== 4'h0 || busBf.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_bf16: got valid=%b result=%h tag=%h flags=%b ready=%b, required 0 0000 0 0000 1",
               busBf.out_valid, busBf.result, busBf.out_tag, busBf.flags, busBf.in_ready);
    end
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fp16_basic();
    issue16(16'h3C00, 16'h3C00, 1'b0, 16'h4000, c_fNone);
    checkLatency16("fp16_first");
    issue16(16'h3C00, 16'h1000, 1'b0, 16'h3C00, c_fInx);
    issue16(16'h3C01, 16'h1000, 1'b0, 16'h3C02, c_fInx);
    issue16(16'h4200, 16'hC000, 1'b0, 16'h3C00, c_fNone);
    drain("fp16_basic");
  endtask

  task automatic test_fp16_specials();
    issue16(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, c_fOvf);
    issue16(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, c_fInv);
    issue16(16'h7E01, 16'h3C00, 1'b0, 16'h7E00, c_fInv);
    issue16(16'h3C00, 16'h3C00, 1'b1, 16'h0000, c_fNone);
    issue16(16'h8000, 16'h8000, 1'b0, 16'h8000, c_fNone);
    issue16(16'hFC00, 16'h3C00, 1'b0, 16'hFC00, c_fNone);
    drain("fp16_specials");
  endtask

  task automatic test_fp16_sub();
    issue16(16'h3C00, 16'h0001, 1'b1, 16'h3C00, c_fNone);
    issue16(16'h0400, 16'h03FF, 1'b1, 16'h0400, c_fNone);
    issue16(16'h0401, 16'h0400, 1'b1, 16'h0000, c_fUnf);
    drain("fp16_sub");
  endtask

  task automatic test_bf16();
    issueBf(16'h3F80, 16'h3F80, 1'b0, 16'h4000, c_fNone);
    issueBf(16'h3F80, 16'hBF80, 1'b0, 16'h0000, c_fNone);
    issueBf(16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, c_fOvf);
    drain("bf16");
  endtask

  task automatic test_back_to_back();
    logic [15:0] opA [6] = '{16'h3C00, 16'h3C00, 16'h3C01, 16'h4200, 16'h3C00, 16'h7BFF};
    logic [15:0] opB [6] = '{16'h3C00, 16'h1000, 16'h1000, 16'hC000, 16'h3C00, 16'h7BFF};
    logic        opS [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] expR[6] = '{16'h4000, 16'h3C00, 16'h3C02, 16'h3C00, 16'h0000, 16'h7C00};
    logic [3:0]  expF[6] = '{c_fNone, c_fInx, c_fInx, c_fNone, c_fNone, c_fOvf};
    logic [15:0] heldRes;
    logic [3:0]  heldTag, heldFlg;
    int startOut;
    startOut = out16;
    tag16 = 4'd1;
    bus16.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue16(opA[i], opB[i], opS[i], expR[i], expF[i]);
      if (i == 1) begin
        checks++;
        if (bus16.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_early: got in_ready=%b after 2 accepts, required 1", bus16.in_ready);
        end
      end
    end
    checks++;
    if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_drop: got in_ready=%b out_valid=%b after 3 accepts, required 0 1",
               bus16.in_ready, bus16.out_valid);
    end
    heldRes = bus16.result;
    heldTag = bus16.out_tag;
    heldFlg = bus16.flags;
    bus16.opr_a = opA[3]; bus16.opr_b = opB[3]; bus16.op_sub = opS[3]; bus16.in_tag = tag16;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus16.result !== heldRes || bus16.out_tag !== heldTag || bus16.flags !== heldFlg ||
          bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got result=%h tag=%h flags=%b valid=%b ready=%b, required %h %h %b 1 0",
                 bus16.result, bus16.out_tag, bus16.flags, bus16.out_valid, bus16.in_ready,
                 heldRes, heldTag, heldFlg);
      end
    end
    bus16.out_ready = 1'b1;
    for (int i = 3; i < 6; i++) issue16(opA[i], opB[i], opS[i], expR[i], expF[i]);
    drain("bp");
    checks++;
    if (out16 - startOut != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d outputs, required 6", out16 - startOut);
    end
  endtask

  task automatic test_async_reset();
    bus16.out_ready = 1'b0;
    issue16(16'h3C00, 16'h3C00, 1'b0, 16'h4000, c_fNone);
    issue16(16'h3C00, 16'h1000, 1'b0, 16'h3C00, c_fInx);
    issue16(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, c_fOvf);
    bus16.in_valid = 1'b0;
    checks++;
    if (bus16.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_prefill: got out_valid=%b, required 1", bus16.out_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_valid: got out_valid=%b in_ready=%b, required 0 1",
               bus16.out_valid, bus16.in_ready);
    end
    checks++;
    if (bus16.result !== 16'h0 || bus16.out_tag !== 4'h0 || bus16.flags !== 4'h0) begin
      errors++;
      $display("FAIL areset_values: got result=%h tag=%h flags=%b, required 0000 0 0000",
               bus16.result, bus16.out_tag, bus16.flags);
    end
    q16.delete();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    issue16(16'h3C01, 16'h1000, 1'b0, 16'h3C02, c_fInx);
    checkLatency16("areset_after");
    drain("areset");
  endtask

  initial begin
    test_reset();
    test_fp16_basic();
    test_fp16_specials();
    test_fp16_sub();
    test_bf16();
    test_back_to_back();
    test_async_reset();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
